// File: rtl/fw_ip2_cfg_shifter_if.sv
// fw_ip2_cfg_shifter_if
// Groups the SW op-code/readback bus and the DUT serial config pins of the
// fw_ip2 configuration shifter. Clock and reset stay outside as plain ports.
//
// Handshake: every op_code_* line is a single-cycle valid strobe with no
// ready; the shifter samples it on the rising edge of fw_clk_100 and always
// consumes it in that cycle. sw_write24_0 is meaningful only in a cycle where
// one of the strobes is high. Outputs are plain registered levels.
interface fw_ip2_cfg_shifter_if;
  logic        op_code_w_reset;
  logic        op_code_w_cfg_array_0;
  logic        op_code_r_cfg_array_0;
  logic        op_code_w_execute;
  logic [23:0] sw_write24_0;
  logic        fw_config_out;
  logic [31:0] read_data32;
  logic [31:0] read_status32;
  logic        fw_config_clk;
  logic        fw_config_in;
  logic        fw_config_load;
  logic [2:0]  dbg_state;

  // SW/op-code decoder side, also models the DUT config chain output.
  modport master (
    output op_code_w_reset, op_code_w_cfg_array_0, op_code_r_cfg_array_0,
    output op_code_w_execute, sw_write24_0, fw_config_out,
    input  read_data32, read_status32, fw_config_clk, fw_config_in,
    input  fw_config_load, dbg_state
  );

  // Shifter side.
  modport slave (
    input  op_code_w_reset, op_code_w_cfg_array_0, op_code_r_cfg_array_0,
    input  op_code_w_execute, sw_write24_0, fw_config_out,
    output read_data32, read_status32, fw_config_clk, fw_config_in,
    output fw_config_load, dbg_state
  );
endinterface

// File: rtl/fw_ip2_cfg_shifter.sv
// fw_ip2_cfg_shifter
// Serial configuration engine for the fw_ip2 slot. SW fills a buffer of
// CFG_WORDS 16-bit words, then an execute op code shifts N bits LSB-first
// (word 0 bit 0 first) to the DUT with a generated config clock of half
// period D+1 cycles, followed by a gap and a config load pulse.
//
// Optional feature macro: FW_IP2_CFG_READBACK_EN. When defined, the DUT
// chain output is captured per bit into a capture array returned in
// read_data32[31:16]; when undefined, there is no capture storage.
//
// Output timing: the FSM moves on the edge that accepts a command, and every
// pin/status output is re-registered from the FSM one edge later, so all
// outputs lag the internal state by exactly one cycle. Soft reset clears the
// output registers directly so that pins and status are 0 on the next cycle.
module fw_ip2_cfg_shifter #(
  parameter int CFG_WORDS = 16
) (
  input  logic                  fw_clk_100,
  input  logic                  fw_rst_n,
  fw_ip2_cfg_shifter_if.slave   bus
);

  localparam logic [4:0] NWORDS   = 5'(CFG_WORDS);
  localparam logic [9:0] MAX_BITS = 10'(16 * CFG_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_GAP   = 3'd4,
    S_LOAD  = 3'd5
  } state_t;

  // FSM state
  state_t      r_state;
  logic [3:0]  r_hcnt;
  logic [3:0]  r_div;
  logic [8:0]  r_nbits;
  logic [7:0]  r_idx;
  logic        r_din;
  logic        r_done;
  logic        r_err;

  // Buffer is always 16 rows so any 4-bit address indexes it; rows at or
  // above CFG_WORDS are never written and stay at their reset value.
  logic [15:0] r_buf [16];

  // Registered outputs
  logic        r_cfg_clk;
  logic        r_cfg_in;
  logic        r_cfg_load;
  logic [31:0] r_status;
  logic [31:0] r_rdata;

  // Payload fields and command decode
  logic [3:0]  w_addr;
  logic [15:0] w_wdata;
  logic [8:0]  w_n;
  logic [3:0]  w_div;
  logic        w_addr_ok;
  logic        w_idle;
  logic        w_do_exec;
  logic        w_do_write;
  logic        w_do_read;
  logic        w_n_ok;
  logic        w_exec_ok;
  logic        w_wr_ok;
  logic        w_err_evt;
  logic        w_phase_end;
  logic        w_more_bits;
  logic [7:0]  w_idx_next;
  logic        w_bit0;
  logic        w_bit_next;
  logic [15:0] w_cap_word;
  logic        w_unused_ok;

  assign w_addr  = bus.sw_write24_0[23:20];
  assign w_wdata = bus.sw_write24_0[15:0];
  assign w_n     = bus.sw_write24_0[8:0];
  assign w_div   = bus.sw_write24_0[15:12];

  assign w_addr_ok = ({1'b0, w_addr} < NWORDS);
  assign w_idle    = (r_state == S_IDLE);

  // Priority: soft reset > execute > write > read; losers are dropped silently.
  assign w_do_exec  = !bus.op_code_w_reset && bus.op_code_w_execute;
  assign w_do_write = !bus.op_code_w_reset && !bus.op_code_w_execute
                      && bus.op_code_w_cfg_array_0;
  assign w_do_read  = !bus.op_code_w_reset && !bus.op_code_w_execute
                      && !bus.op_code_w_cfg_array_0 && bus.op_code_r_cfg_array_0;

  assign w_n_ok    = (w_n != 9'd0) && ({1'b0, w_n} <= MAX_BITS);
  assign w_exec_ok = w_do_exec && w_idle && w_n_ok;
  assign w_wr_ok   = w_do_write && w_idle && w_addr_ok;
  assign w_err_evt = (w_do_exec && !w_exec_ok)
                   || (w_do_write && !w_wr_ok)
                   || (w_do_read && !w_addr_ok);

  assign w_phase_end = (r_hcnt == r_div);
  assign w_more_bits = ({1'b0, r_idx} < (r_nbits - 9'd1));
  assign w_idx_next  = r_idx + 8'd1;
  assign w_bit0      = r_buf[0][0];
  assign w_bit_next  = r_buf[w_idx_next[7:4]][w_idx_next[3:0]];

  // Shift sequencer: walks SETUP/HIGH/LOW.../GAP/LOAD, each phase H cycles.
  always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_div   <= '0;
      r_nbits <= '0;
      r_idx   <= '0;
      r_din   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (bus.op_code_w_reset) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_div   <= '0;
      r_nbits <= '0;
      r_idx   <= '0;
      r_din   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
      if (r_state != S_IDLE) begin
        r_hcnt <= w_phase_end ? 4'd0 : r_hcnt + 4'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_exec_ok) begin
            r_state <= S_SETUP;
            r_hcnt  <= '0;
            r_div   <= w_div;
            r_nbits <= w_n;
            r_idx   <= '0;
            r_din   <= w_bit0;
            r_done  <= 1'b0;
          end
        end
        S_SETUP: begin
          if (w_phase_end) begin
            r_state <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (w_phase_end) begin
            if (w_more_bits) begin
              r_state <= S_LOW;
              r_idx   <= w_idx_next;
              r_din   <= w_bit_next;
            end else begin
              r_state <= S_GAP;
              r_din   <= 1'b0;
            end
          end
        end
        S_LOW: begin
          if (w_phase_end) begin
            r_state <= S_HIGH;
          end
        end
        S_GAP: begin
          if (w_phase_end) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_phase_end) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Config buffer: SW writes only while idle and in range; survives soft reset.
  always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_buf[w_addr] <= w_wdata;
    end
  end

`ifdef FW_IP2_CFG_READBACK_EN
  logic [15:0] r_cap [16];
  logic        w_capture;

  // The capture edge is the one that raises the config clock pin, so the
  // chain output is sampled while config_in has already been stable H cycles.
  assign w_capture = (r_state == S_HIGH) && (r_hcnt == 4'd0) && !bus.op_code_w_reset;

  // Capture array: chain output per shifted bit; survives soft reset.
  always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_cap[i] <= '0;
      end
    end else if (w_capture) begin
      r_cap[r_idx[7:4]][r_idx[3:0]] <= bus.fw_config_out;
    end
  end

  assign w_cap_word  = r_cap[w_addr];
  assign w_unused_ok = &{1'b0, bus.sw_write24_0[19:16], bus.sw_write24_0[11:9]};
`else
  assign w_cap_word  = '0;
  assign w_unused_ok = &{1'b0, bus.fw_config_out, bus.sw_write24_0[19:16],
                         bus.sw_write24_0[11:9]};
`endif

  // Readback register: loads on an accepted read, holds otherwise.
  always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      r_rdata <= '0;
    end else if (bus.op_code_w_reset) begin
      r_rdata <= '0;
    end else if (w_do_read) begin
      r_rdata <= w_addr_ok ? {w_cap_word, r_buf[w_addr]} : 32'h0;
    end
  end

  // Output stage: pins and status re-registered from the sequencer state.
  always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      r_cfg_clk  <= 1'b0;
      r_cfg_in   <= 1'b0;
      r_cfg_load <= 1'b0;
      r_status   <= '0;
    end else if (bus.op_code_w_reset) begin
      r_cfg_clk  <= 1'b0;
      r_cfg_in   <= 1'b0;
      r_cfg_load <= 1'b0;
      r_status   <= '0;
    end else begin
      r_cfg_clk  <= (r_state == S_HIGH);
      r_cfg_in   <= r_din;
      r_cfg_load <= (r_state == S_LOAD);
      r_status   <= {7'b0, r_nbits, 13'b0, r_err, r_done, (r_state != S_IDLE)};
    end
  end

  assign bus.fw_config_clk  = r_cfg_clk;
  assign bus.fw_config_in   = r_cfg_in;
  assign bus.fw_config_load = r_cfg_load;
  assign bus.read_status32  = r_status;
  assign bus.read_data32    = r_rdata;
  assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_fw_ip2_cfg_shifter.sv
// tb_fw_ip2_cfg_shifter
// Directed bench for fw_ip2_cfg_shifter with CFG_WORDS=8. A small buffer
// model supplies the expected serial bit stream; pin timing is measured
// cycle by cycle against the half period H = D+1.
module tb_fw_ip2_cfg_shifter;
  localparam int CFG_WORDS = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tb_loop;
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] m_buf [16];

  fw_ip2_cfg_shifter_if bus();

  fw_ip2_cfg_shifter #(.CFG_WORDS(CFG_WORDS)) dut (
    .fw_clk_100 (clk),
    .fw_rst_n   (rst_n),
    .bus        (bus)
  );

  assign bus.fw_config_out = tb_loop ? bus.fw_config_in : 1'b0;

  // clock
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] exec_pl(input int n, input int d);
    logic [8:0] nn;
    logic [3:0] dd;
    nn = n[8:0];
    dd = d[3:0];
    return {8'h00, dd, 3'b000, nn};
  endfunction

  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    bus.sw_write24_0 = {a, 4'h0, d};
    bus.op_code_w_cfg_array_0 = 1'b1;
    tick();
    bus.op_code_w_cfg_array_0 = 1'b0;
    if (int'(a) < CFG_WORDS) m_buf[a] = d;
  endtask

  task automatic do_read(input logic [3:0] a);
    bus.sw_write24_0 = {a, 20'h0};
    bus.op_code_r_cfg_array_0 = 1'b1;
    tick();
    bus.op_code_r_cfg_array_0 = 1'b0;
  endtask

  task automatic do_exec(input int n, input int d);
    bus.sw_write24_0 = exec_pl(n, d);
    bus.op_code_w_execute = 1'b1;
    tick();
    bus.op_code_w_execute = 1'b0;
  endtask

  task automatic do_soft_reset();
    bus.op_code_w_reset = 1'b1;
    tick();
    bus.op_code_w_reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tb_loop = 1'b0;
    bus.op_code_w_reset = 1'b0;
    bus.op_code_w_cfg_array_0 = 1'b0;
    bus.op_code_r_cfg_array_0 = 1'b0;
    bus.op_code_w_execute = 1'b0;
    bus.sw_write24_0 = '0;
    for (int i = 0; i < 16; i++) m_buf[i] = '0;
    repeat (3) tick();
    vec_cnt++; if (bus.read_data32 !== 32'h0) begin err_cnt++; $display("FAIL reset_rdata: got %h expected %h", bus.read_data32, 32'h0); end
    vec_cnt++; if (bus.read_status32 !== 32'h0) begin err_cnt++; $display("FAIL reset_status: got %h expected %h", bus.read_status32, 32'h0); end
    vec_cnt++; if ({bus.fw_config_clk, bus.fw_config_in, bus.fw_config_load} !== 3'b000) begin err_cnt++; $display("FAIL reset_pins: got %b expected 000", {bus.fw_config_clk, bus.fw_config_in, bus.fw_config_load}); end
    rst_n = 1'b1;
    repeat (2) tick();
    vec_cnt++; if (bus.dbg_state !== 3'd0) begin err_cnt++; $display("FAIL reset_state: got %0d expected 0", bus.dbg_state); end
    vec_cnt++; if (bus.read_status32 !== 32'h0) begin err_cnt++; $display("FAIL post_reset_status: got %h expected %h", bus.read_status32, 32'h0); end
  endtask

  task automatic test_write_read();
    do_write(4'd0, 16'hA5C3);
    do_write(4'd1, 16'h0001);
    do_read(4'd1);
    vec_cnt++; if (bus.read_data32 !== 32'h0000_0001) begin err_cnt++; $display("FAIL rd_addr1: got %h expected %h", bus.read_data32, 32'h0000_0001); end
    do_read(4'd0);
    vec_cnt++; if (bus.read_data32 !== 32'h0000_A5C3) begin err_cnt++; $display("FAIL rd_addr0: got %h expected %h", bus.read_data32, 32'h0000_A5C3); end
    tick();
    vec_cnt++; if (bus.read_status32 !== 32'h0) begin err_cnt++; $display("FAIL wr_status_clean: got %h expected %h", bus.read_status32, 32'h0); end
    do_read(4'd15);
    vec_cnt++; if (bus.read_data32 !== 32'h0) begin err_cnt++; $display("FAIL rd_oor_data: got %h expected %h", bus.read_data32, 32'h0); end
    tick();
    vec_cnt++; if (bus.read_status32 !== 32'h4) begin err_cnt++; $display("FAIL rd_oor_err: got %h expected %h", bus.read_status32, 32'h4); end
    do_soft_reset();
    vec_cnt++; if (bus.read_status32 !== 32'h0) begin err_cnt++; $display("FAIL srst_status: got %h expected %h", bus.read_status32, 32'h0); end
    do_write(4'd8, 16'hFFFF);
    tick();
    vec_cnt++; if (bus.read_status32 !== 32'h4) begin err_cnt++; $display("FAIL wr_oor_err: got %h expected %h", bus.read_status32, 32'h4); end
    do_read(4'd0);
    vec_cnt++; if (bus.read_data32 !== 32'h0000_A5C3) begin err_cnt++; $display("FAIL wr_oor_alias: got %h expected %h", bus.read_data32, 32'h0000_A5C3); end
    do_soft_reset();
  endtask

  task automatic test_priority();
    do_read(4'd1);
    vec_cnt++; if (bus.read_data32 !== 32'h0000_0001) begin err_cnt++; $display("FAIL pri_pre_read: got %h expected %h", bus.read_data32, 32'h0000_0001); end
    // write beats read: data lands, readback holds
    bus.sw_write24_0 = {4'd2, 4'h0, 16'h1234};
    bus.op_code_w_cfg_array_0 = 1'b1;
    bus.op_code_r_cfg_array_0 = 1'b1;
    tick();
    bus.op_code_w_cfg_array_0 = 1'b0;
    bus.op_code_r_cfg_array_0 = 1'b0;
    m_buf[2] = 16'h1234;
    vec_cnt++; if (bus.read_data32 !== 32'h0000_0001) begin err_cnt++; $display("FAIL pri_wr_over_rd_hold: got %h expected %h", bus.read_data32, 32'h0000_0001); end
    do_read(4'd2);
    vec_cnt++; if (bus.read_data32 !== 32'h0000_1234) begin err_cnt++; $display("FAIL pri_wr_over_rd_data: got %h expected %h", bus.read_data32, 32'h0000_1234); end
    // execute (N=0, rejected) beats write to addr 0 of 0x0000
    bus.sw_write24_0 = 24'h0;
    bus.op_code_w_execute = 1'b1;
    bus.op_code_w_cfg_array_0 = 1'b1;
    tick();
    bus.op_code_w_execute = 1'b0;
    bus.op_code_w_cfg_array_0 = 1'b0;
    tick();
    vec_cnt++; if (bus.read_status32 !== 32'h4) begin err_cnt++; $display("FAIL pri_ex_over_wr_err: got %h expected %h", bus.read_status32, 32'h4); end
    do_read(4'd0);
    vec_cnt++; if (bus.read_data32 !== 32'h0000_A5C3) begin err_cnt++; $display("FAIL pri_ex_over_wr_buf: got %h expected %h", bus.read_data32, 32'h0000_A5C3); end
    // soft reset beats a valid execute
    bus.sw_write24_0 = exec_pl(20, 0);
    bus.op_code_w_reset = 1'b1;
    bus.op_code_w_execute = 1'b1;
    tick();
    bus.op_code_w_reset = 1'b0;
    bus.op_code_w_execute = 1'b0;
    repeat (3) tick();
    vec_cnt++; if (bus.read_status32 !== 32'h0) begin err_cnt++; $display("FAIL pri_rst_over_ex: got %h expected %h", bus.read_status32, 32'h0); end
  endtask

  // Runs one shift and measures pins; optionally injects a write (kind 1)
  // or a second execute (kind 2) at sample inj_at, which must be rejected.
  task automatic test_shift(input string name, input int n, input int d,
                            input int inj_at, input int inj_kind);
    logic [0:0]  exp_q[$];
    logic [0:0]  exp_bit;
    logic [3:0]  wi, bi;
    logic [8:0]  nn;
    logic [31:0] exp_status;
    logic        clk_prev, load_prev, in_at_rise, ended;
    int h, busy_cnt, rises, first_rise, last_fall, load_start, load_len;
    int load_runs, hi_run, lo_run, bit_errs, run_errs, overlap;
    h = d + 1;
    busy_cnt = 0; rises = 0; first_rise = -1; last_fall = -1; load_start = -1;
    load_len = 0; load_runs = 0; hi_run = 0; lo_run = 0; bit_errs = 0;
    run_errs = 0; overlap = 0; clk_prev = 1'b0; load_prev = 1'b0;
    in_at_rise = 1'b0; ended = 1'b0;
    for (int i = 0; i < n; i++) begin
      wi = 4'(i / 16);
      bi = 4'(i % 16);
      exp_q.push_back(m_buf[wi][bi]);
    end
    do_soft_reset();
    do_exec(n, d);
    for (int c = 0; c < 4000 && !ended; c++) begin
      if (c == inj_at) begin
        if (inj_kind == 1) begin
          bus.sw_write24_0 = {4'h0, 4'h0, 16'hFFFF};
          bus.op_code_w_cfg_array_0 = 1'b1;
        end else begin
          bus.sw_write24_0 = exec_pl(4, 0);
          bus.op_code_w_execute = 1'b1;
        end
      end
      tick();
      bus.op_code_w_cfg_array_0 = 1'b0;
      bus.op_code_w_execute = 1'b0;
      if (bus.read_status32[0]) busy_cnt++;
      else if (busy_cnt > 0) ended = 1'b1;
      if (bus.fw_config_clk && !clk_prev) begin
        rises++;
        if (rises == 1) first_rise = c;
        else if (lo_run != h) run_errs++;
        if (exp_q.size() == 0) bit_errs++;
        else begin
          exp_bit = exp_q.pop_front();
          if (bus.fw_config_in !== exp_bit[0]) bit_errs++;
        end
        in_at_rise = bus.fw_config_in;
        hi_run = 0;
      end
      if (!bus.fw_config_clk && clk_prev) begin
        if (hi_run != h) run_errs++;
        last_fall = c;
        lo_run = 0;
      end
      if (bus.fw_config_clk) begin
        hi_run++;
        if (bus.fw_config_in !== in_at_rise) run_errs++;
      end else begin
        lo_run++;
      end
      if (bus.fw_config_load && !load_prev) begin
        load_runs++;
        load_start = c;
        load_len = 0;
      end
      if (bus.fw_config_load) begin
        load_len++;
        if (bus.fw_config_clk) overlap++;
      end
      clk_prev = bus.fw_config_clk;
      load_prev = bus.fw_config_load;
    end
    nn = n[8:0];
    exp_status = {7'b0, nn, 13'b0, (inj_kind != 0), 1'b1, 1'b0};
    vec_cnt++; if (!ended) begin err_cnt++; $display("FAIL %s_timeout: busy never fell, busy cycles %0d", name, busy_cnt); end
    vec_cnt++; if (busy_cnt != h * (2 * n + 2)) begin err_cnt++; $display("FAIL %s_busy_len: got %0d expected %0d", name, busy_cnt, h * (2 * n + 2)); end
    vec_cnt++; if (rises != n) begin err_cnt++; $display("FAIL %s_clk_pulses: got %0d expected %0d", name, rises, n); end
    vec_cnt++; if (first_rise != h) begin err_cnt++; $display("FAIL %s_setup_len: got %0d expected %0d", name, first_rise, h); end
    vec_cnt++; if (bit_errs != 0) begin err_cnt++; $display("FAIL %s_bits: got %0d wrong bits expected 0", name, bit_errs); end
    vec_cnt++; if (run_errs != 0) begin err_cnt++; $display("FAIL %s_clk_timing: got %0d bad phases expected 0", name, run_errs); end
    vec_cnt++; if (load_runs != 1 || load_len != h) begin err_cnt++; $display("FAIL %s_load: got %0d pulses len %0d expected 1 len %0d", name, load_runs, load_len, h); end
    vec_cnt++; if (load_start - last_fall != h) begin err_cnt++; $display("FAIL %s_gap: got %0d expected %0d", name, load_start - last_fall, h); end
    vec_cnt++; if (overlap != 0) begin err_cnt++; $display("FAIL %s_load_clk_overlap: got %0d expected 0", name, overlap); end
    vec_cnt++; if (bus.read_status32 !== exp_status) begin err_cnt++; $display("FAIL %s_status: got %h expected %h", name, bus.read_status32, exp_status); end
  endtask

  task automatic test_rejects();
    int act;
    do_soft_reset();
    do_exec(0, 0);
    act = 0;
    repeat (10) begin
      tick();
      if (bus.fw_config_clk || bus.fw_config_load || bus.read_status32[0]) act++;
    end
    vec_cnt++; if (act != 0) begin err_cnt++; $display("FAIL rej_n0_activity: got %0d active cycles expected 0", act); end
    vec_cnt++; if (bus.read_status32 !== 32'h4) begin err_cnt++; $display("FAIL rej_n0_status: got %h expected %h", bus.read_status32, 32'h4); end
    do_soft_reset();
    do_exec(CFG_WORDS * 16 + 1, 0);
    act = 0;
    repeat (10) begin
      tick();
      if (bus.fw_config_clk || bus.fw_config_load || bus.read_status32[0]) act++;
    end
    vec_cnt++; if (act != 0) begin err_cnt++; $display("FAIL rej_nmax_activity: got %0d active cycles expected 0", act); end
    vec_cnt++; if (bus.read_status32 !== 32'h4) begin err_cnt++; $display("FAIL rej_nmax_status: got %h expected %h", bus.read_status32, 32'h4); end
  endtask

  task automatic test_busy_reject();
    test_shift("wr_busy", 20, 2, 10, 1);
    do_read(4'd0);
    vec_cnt++; if (bus.read_data32 !== 32'h0000_A5C3) begin err_cnt++; $display("FAIL wr_busy_buf: got %h expected %h", bus.read_data32, 32'h0000_A5C3); end
    test_shift("ex_busy", 20, 0, 5, 2);
  endtask

  task automatic test_soft_reset_mid();
    logic clk_prev;
    int   rises, act;
    do_soft_reset();
    do_read(4'd0);
    vec_cnt++; if (bus.read_data32 !== 32'h0000_A5C3) begin err_cnt++; $display("FAIL srst_pre_read: got %h expected %h", bus.read_data32, 32'h0000_A5C3); end
    do_exec(20, 0);
    rises = 0;
    clk_prev = 1'b0;
    for (int c = 0; c < 200 && rises < 10; c++) begin
      tick();
      if (bus.fw_config_clk && !clk_prev) rises++;
      clk_prev = bus.fw_config_clk;
    end
    vec_cnt++; if (rises != 10) begin err_cnt++; $display("FAIL srst_reach_bit10: got %0d rises expected 10", rises); end
    do_soft_reset();
    vec_cnt++; if ({bus.fw_config_clk, bus.fw_config_in, bus.fw_config_load} !== 3'b000) begin err_cnt++; $display("FAIL srst_pins: got %b expected 000", {bus.fw_config_clk, bus.fw_config_in, bus.fw_config_load}); end
    vec_cnt++; if (bus.read_status32 !== 32'h0) begin err_cnt++; $display("FAIL srst_mid_status: got %h expected %h", bus.read_status32, 32'h0); end
    vec_cnt++; if (bus.read_data32 !== 32'h0) begin err_cnt++; $display("FAIL srst_rdata: got %h expected %h", bus.read_data32, 32'h0); end
    vec_cnt++; if (bus.dbg_state !== 3'd0) begin err_cnt++; $display("FAIL srst_state: got %0d expected 0", bus.dbg_state); end
    act = 0;
    repeat (6) begin
      tick();
      if (bus.fw_config_clk || bus.fw_config_in || bus.fw_config_load || bus.read_status32 != 32'h0) act++;
    end
    vec_cnt++; if (act != 0) begin err_cnt++; $display("FAIL srst_quiet: got %0d active cycles expected 0", act); end
    do_read(4'd0);
    vec_cnt++; if (bus.read_data32 !== 32'h0000_A5C3) begin err_cnt++; $display("FAIL srst_buf_kept: got %h expected %h", bus.read_data32, 32'h0000_A5C3); end
  endtask

  task automatic test_readback();
    logic [31:0] exp0;
    int          busy_cnt;
    logic        ended;
`ifdef FW_IP2_CFG_READBACK_EN
    exp0 = 32'hA5C3_A5C3;
`else
    exp0 = 32'h0000_A5C3;
`endif
    do_soft_reset();
    tb_loop = 1'b1;
    do_exec(16, 0);
    busy_cnt = 0;
    ended = 1'b0;
    for (int c = 0; c < 300 && !ended; c++) begin
      tick();
      if (bus.read_status32[0]) busy_cnt++;
      else if (busy_cnt > 0) ended = 1'b1;
    end
    tb_loop = 1'b0;
    vec_cnt++; if (!ended) begin err_cnt++; $display("FAIL rb_timeout: busy never fell, busy cycles %0d", busy_cnt); end
    do_read(4'd0);
    vec_cnt++; if (bus.read_data32 !== exp0) begin err_cnt++; $display("FAIL rb_word0: got %h expected %h", bus.read_data32, exp0); end
    do_read(4'd1);
    vec_cnt++; if (bus.read_data32 !== 32'h0000_0001) begin err_cnt++; $display("FAIL rb_word1: got %h expected %h", bus.read_data32, 32'h0000_0001); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_priority();
    test_shift("basic", 20, 0, -1, 0);
    test_shift("div", 4, 3, -1, 0);
    test_rejects();
    test_busy_reject();
    test_shift("max", CFG_WORDS * 16, 0, -1, 0);
    test_soft_reset_mid();
    test_readback();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fw_ip2_cfg_shifter.md
# fw_ip2_cfg_shifter

- Serial configuration engine for the fw_ip2 slot, downstream of the op-code decoder and driving the DUT config pins.
- Buffers configuration words written from SW in a local register array.
- On an execute op code, shifts a programmable number of bits to the DUT using a generated config clock, then pulses config load.
- Reports busy/done/error status and word readback to the SW read path.

## Interface
- CFG_WORDS, 16, depth of the 16-bit config buffer; legal 2..16, so at most 256 bits.
- fw_clk_100  in  1  FW clock, 100 MHz; the only clock.
- fw_rst_n  in  1  FW reset; asynchronous, active-low.
- op_code_w_reset  in  1  one-cycle soft-reset strobe.
- op_code_w_cfg_array_0  in  1  one-cycle buffer write strobe.
- op_code_r_cfg_array_0  in  1  one-cycle buffer read strobe.
- op_code_w_execute  in  1  one-cycle shift start strobe.
- sw_write24_0  in  24  payload, qualified by the strobes above.
- fw_config_out  in  1  DUT config chain output.
- read_data32  out  32  readback word.
- read_status32  out  32  status word.
- fw_config_clk  out  1  generated config clock.
- fw_config_in  out  1  serial data to DUT.
- fw_config_load  out  1  load pulse to DUT.

## Operation
- Write: on op_code_w_cfg_array_0, buf[sw_write24_0[23:20]] <= sw_write24_0[15:0].
  - Address >= CFG_WORDS: write ignored, error set.
  - Write while busy: ignored, error set.
- Read: on op_code_r_cfg_array_0 at address a = sw_write24_0[23:20], read_data32 <= {cap[a], buf[a]}.
  - Address out of range returns 0.
  - read_data32 holds its value until the next read.
- Execute payload fields:
  - N = sw_write24_0[8:0], the bit count.
  - D = sw_write24_0[15:12], the divider; half-period H = D+1 cycles.
- Execute is rejected (error set, state stays IDLE) when N == 0, N > 16*CFG_WORDS, or busy.
- Bit order: bit i = buf[i/16][i%16], so word 0 bit 0 is sent first.
- FSM states: IDLE, SETUP, HIGH, LOW, GAP, LOAD.
  - IDLE -> SETUP on an accepted execute; clear done, set busy, load i=0.
  - SETUP: clk=0, config_in=bit 0, for H cycles, then -> HIGH.
  - HIGH: clk=1 for H cycles. On entry, sample fw_config_out into cap bit i. Then -> LOW if i < N-1, else -> GAP.
  - LOW: clk=0; i++ and config_in=bit i on entry; hold H cycles, then -> HIGH.
  - GAP: clk=0, config_in=0, for H cycles, then -> LOAD.
  - LOAD: config_load=1 for H cycles, then -> IDLE; clear busy, set done.
- read_status32 layout:
  - [0] busy.
  - [1] done, sticky; cleared by the next accepted execute.
  - [2] error, sticky; cleared by op_code_w_reset only.
  - [24:16] N of the last accepted execute.
  - All other bits 0.
- Strobe priority, if more than one is asserted in a cycle: w_reset > execute > write > read; lower-priority strobes are ignored.
- op_code_w_reset, including mid-shift:
  - Next cycle: FSM in IDLE; clk, config_in and load are 0; status is 0; read_data32 is 0.
  - buf and cap are retained.
- fw_rst_n low: all registers, buf and cap cleared to 0 asynchronously.

## Timing
- All outputs are registered; reset value of every output is 0.
- Execute sampled at edge k: SETUP outputs are visible after edge k+1.
- Busy falls after edge k+1+H*(2N+2).
- Config clock period is 2H; duty cycle is 50%.
- config_in changes only on config_clk falling transitions and in SETUP, so it is stable H cycles before each rising edge.
- config_load rises H cycles after the last config_clk falling edge and is never high while config_clk is high.
- Readback latency: 1 cycle after the read strobe.
- Status updates 1 cycle after the causing event.

## Configuration
- FW_IP2_CFG_READBACK_EN defined:
  - cap array is implemented; fw_config_out is captured in HIGH entry as above.
  - read_data32[31:16] = cap[a].
- FW_IP2_CFG_READBACK_EN undefined:
  - No cap storage; fw_config_out is unused.
  - read_data32[31:16] = 0.

## Test plan
- Write buf[0]=16'hA5C3 and buf[1]=16'h0001, then read address 1 -> read_data32=32'h0000_0001 (readback undefined) one cycle later. Read address 15 with CFG_WORDS=8 -> 0, error bit set.
- Execute N=20, D=0 -> busy for 42 cycles. config_in sequence is the LSB-first bits of 0xA5C3, then 1,0,0,0. 20 clk pulses with period 2 cycles, one load pulse of 1 cycle, done=1, status[24:16]=20.
- Execute N=4, D=3 -> each clk level lasts 4 cycles; busy lasts 40 cycles; config_load is high for 4 cycles, starting 4 cycles after the last clk fall.
- Execute with N=0, then a write during a shift -> error=1, no clk activity from the rejected execute, buffer unchanged. The running shift is unaffected.
- op_code_w_reset at bit 10 of a 20-bit shift -> next cycle all DUT pins are 0 and status=0; buf still reads 0xA5C3.
- With FW_IP2_CFG_READBACK_EN defined, loop fw_config_out to fw_config_in and run N=16 -> read address 0 returns 32'hA5C3_A5C3.
